// File: rtl/decode_queue_pkg.sv
// ---------------------------------------------------------------------------
// Shared types for the decode front-end.
//   selector        : PC-source / operand-use / ALU selector enums
//   signals         : control_t, the decoded control word
//   decoder_util    : get_default_control(), the idle/NOP control word
//   decode_queue_pkg: queue entry type, is_cti() and width helpers
// ---------------------------------------------------------------------------
package selector;
    typedef enum logic [2:0] {
        PC_SRC_NEXT      = 3'd0,
        PC_SRC_JUMP      = 3'd1,
        PC_SRC_BRANCH    = 3'd2,
        PC_SRC_JUMP_REG  = 3'd3,
        PC_SRC_EXECPTION = 3'd4
    } pc_src_t;

    typedef enum logic [1:0] {
        OPERAND_USE_NONE  = 2'd0,
        OPERAND_USE_RS    = 2'd1,
        OPERAND_USE_RT    = 2'd2,
        OPERAND_USE_RS_RT = 2'd3
    } operand_use_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLL = 3'd4,
        ALU_LUI = 3'd5
    } alu_op_t;
endpackage

package signals;
    typedef struct packed {
        selector::pc_src_t      pc_src;
        selector::operand_use_t opd_use;
        selector::alu_op_t      alu_op;
        logic                   reg_write;
        logic                   mem_read;
        logic                   mem_write;
        logic                   imm_signed;
    } control_t;
endpackage

package decoder_util;
    // All-zero control: falls through to PC+4 and touches no state.
    function automatic signals::control_t get_default_control();
        signals::control_t c;
        c.pc_src     = selector::PC_SRC_NEXT;
        c.opd_use    = selector::OPERAND_USE_NONE;
        c.alu_op     = selector::ALU_ADD;
        c.reg_write  = 1'b0;
        c.mem_read   = 1'b0;
        c.mem_write  = 1'b0;
        c.imm_signed = 1'b0;
        return c;
    endfunction
endpackage

package decode_queue_pkg;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    // Control-transfer instructions open a delay slot for the next one.
    function automatic logic is_cti(input signals::control_t ctl);
        return (ctl.pc_src == selector::PC_SRC_JUMP)   ||
               (ctl.pc_src == selector::PC_SRC_BRANCH) ||
               (ctl.pc_src == selector::PC_SRC_JUMP_REG);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Level must represent DEPTH itself, hence depth+1.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/decode_queue_if.sv
// ---------------------------------------------------------------------------
// Fetch-side and consumer-side handshake bundle of decode_queue.
//   in_*  : fetch offers in_count packed lanes at in_pc (lane k at in_pc+4k)
//   out_* : one registered decoded instruction per cycle, valid/ready
// master = fetch + consumer (driver side), slave = decode_queue.
// ---------------------------------------------------------------------------
interface decode_queue_if #(
    parameter int FETCH_WIDTH = 2
);
    logic                               in_valid;
    logic                               in_ready;
    logic [$clog2(FETCH_WIDTH+1)-1:0]   in_count;
    logic [32*FETCH_WIDTH-1:0]          in_instr;
    logic [31:0]                        in_pc;

    logic                               out_valid;
    logic                               out_ready;
    logic [31:0]                        out_instr;
    logic [31:0]                        out_pc;
    signals::control_t                  out_ctl;
    logic                               out_delay_slot;

    modport master (
        output in_valid, in_count, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_ctl, out_delay_slot
    );

    modport slave (
        input  in_valid, in_count, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_ctl, out_delay_slot
    );
endinterface

// File: rtl/decode_queue_ram.sv
// ---------------------------------------------------------------------------
// DEPTH x entry_t storage for decode_queue.
//   we/waddr/wdata : FETCH_WIDTH independent write lanes (lane k at
//                    waddr[k*PW +: PW])
//   raddr/rdata    : asynchronous head read, so the decoder sees the head
//                    entry in the same cycle it is loaded
// ---------------------------------------------------------------------------
module decode_queue_ram
    import decode_queue_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int FETCH_WIDTH = 2
)(
    input  logic                                   clk,
    input  logic [FETCH_WIDTH-1:0]                 we,
    input  logic [FETCH_WIDTH*ptr_width(DEPTH)-1:0] waddr,
    input  entry_t [FETCH_WIDTH-1:0]               wdata,
    input  logic [ptr_width(DEPTH)-1:0]            raddr,
    output entry_t                                 rdata
);
    localparam int PW = ptr_width(DEPTH);

    entry_t mem [DEPTH];

    // Lanes always target distinct addresses, so write order is irrelevant.
    always_ff @(posedge clk) begin
        for (int l = 0; l < FETCH_WIDTH; l++) begin
            if (we[l]) begin
                mem[waddr[l*PW +: PW]] <= wdata[l];
            end
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/main_decoder.sv
// ---------------------------------------------------------------------------
// Combinational MIPS-subset main decoder.
//   instr : 32-bit instruction word
//   ctl   : decoded control word; unknown encodings select PC_SRC_EXECPTION
// ---------------------------------------------------------------------------
module main_decoder
    import selector::*;
(
    input  logic [31:0]       instr,
    output signals::control_t ctl
);
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    // Register/immediate fields are consumed downstream, not here.
    assign unused_fields = ^instr[25:6];

    always_comb begin
        ctl = decoder_util::get_default_control();
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h00: begin ctl.opd_use = OPERAND_USE_RT;    ctl.alu_op = ALU_SLL; ctl.reg_write = 1'b1; end
                    6'h08: begin ctl.opd_use = OPERAND_USE_RS;    ctl.pc_src = PC_SRC_JUMP_REG; end
                    6'h21: begin ctl.opd_use = OPERAND_USE_RS_RT; ctl.alu_op = ALU_ADD; ctl.reg_write = 1'b1; end
                    6'h23: begin ctl.opd_use = OPERAND_USE_RS_RT; ctl.alu_op = ALU_SUB; ctl.reg_write = 1'b1; end
                    6'h24: begin ctl.opd_use = OPERAND_USE_RS_RT; ctl.alu_op = ALU_AND; ctl.reg_write = 1'b1; end
                    6'h25: begin ctl.opd_use = OPERAND_USE_RS_RT; ctl.alu_op = ALU_OR;  ctl.reg_write = 1'b1; end
                    default: ctl.pc_src = PC_SRC_EXECPTION;
                endcase
            end
            6'h02: ctl.pc_src = PC_SRC_JUMP;
            6'h03: begin ctl.pc_src = PC_SRC_JUMP; ctl.reg_write = 1'b1; end
            6'h04, 6'h05: begin
                ctl.pc_src  = PC_SRC_BRANCH;
                ctl.opd_use = OPERAND_USE_RS_RT;
                ctl.alu_op  = ALU_SUB;
            end
            6'h09: begin ctl.opd_use = OPERAND_USE_RS; ctl.reg_write = 1'b1; ctl.imm_signed = 1'b1; end
            6'h0C: begin ctl.opd_use = OPERAND_USE_RS; ctl.alu_op = ALU_AND; ctl.reg_write = 1'b1; end
            6'h0D: begin ctl.opd_use = OPERAND_USE_RS; ctl.alu_op = ALU_OR;  ctl.reg_write = 1'b1; end
            6'h0F: begin ctl.alu_op = ALU_LUI; ctl.reg_write = 1'b1; end
            6'h23: begin
                ctl.opd_use    = OPERAND_USE_RS;
                ctl.reg_write  = 1'b1;
                ctl.mem_read   = 1'b1;
                ctl.imm_signed = 1'b1;
            end
            6'h2B: begin
                ctl.opd_use    = OPERAND_USE_RS_RT;
                ctl.mem_write  = 1'b1;
                ctl.imm_signed = 1'b1;
            end
            default: ctl.pc_src = PC_SRC_EXECPTION;
        endcase
    end
endmodule

// File: rtl/decode_queue.sv
// ---------------------------------------------------------------------------
// Buffered decode front-end: up to FETCH_WIDTH instructions per cycle are
// queued, the head is decoded and presented as one registered control word
// per cycle, tagged with its PC and delay-slot status.
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : synchronous discard of queue, output and halt state
//   bus (slave)  : in_* fetch handshake, out_* decoded-output handshake
//   halted       : dequeue stopped after an exception-class decode
//   level        : occupied queue entries (output register excluded)
// ---------------------------------------------------------------------------
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int FETCH_WIDTH = 2,
    parameter int STOP_ON_EXC = 1
)(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    decode_queue_if.slave                 bus,
    output logic                          halted,
    output logic [level_width(DEPTH)-1:0] level
);
    localparam int   PW   = ptr_width(DEPTH);
    localparam int   LW   = level_width(DEPTH);
    localparam int   CW   = $clog2(FETCH_WIDTH + 1);
    localparam logic STOP = (STOP_ON_EXC != 0);

    logic [PW-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0]      level_reg, level_next;
    logic               out_valid_reg, out_valid_next;
    logic               out_ds_reg, out_ds_next;
    logic               cti_pending_reg, cti_pending_next;
    logic               halted_reg, halted_next;
    entry_t             out_entry_reg, out_entry_next;
    signals::control_t  out_ctl_reg, out_ctl_next;

    logic                     enq;
    logic                     load;
    logic [FETCH_WIDTH-1:0]   lane_we;
    logic [FETCH_WIDTH*PW-1:0] lane_addr;
    entry_t [FETCH_WIDTH-1:0] lane_data;
    entry_t                   head_entry;
    signals::control_t        head_ctl;

    // Registered level only: no path from out_ready into in_ready.
    assign bus.in_ready = (LW'(DEPTH) - level_reg) >= LW'(FETCH_WIDTH);
    assign enq          = bus.in_valid && bus.in_ready;
    assign load         = (level_reg != '0) && (!out_valid_reg || bus.out_ready) && !halted_reg;

    generate
        for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_lane
            assign lane_we[gi]              = enq && (CW'(gi) < bus.in_count);
            assign lane_addr[gi*PW +: PW]   = wr_ptr_reg + PW'(gi);
            assign lane_data[gi].instr      = bus.in_instr[32*gi +: 32];
            assign lane_data[gi].pc         = bus.in_pc + 32'(4*gi);
        end
    endgenerate

    decode_queue_ram #(
        .DEPTH       (DEPTH),
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (lane_we),
        .waddr (lane_addr),
        .wdata (lane_data),
        .raddr (rd_ptr_reg),
        .rdata (head_entry)
    );

    main_decoder u_dec (
        .instr (head_entry.instr),
        .ctl   (head_ctl)
    );

    always_comb begin
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        level_next       = level_reg;
        out_valid_next   = out_valid_reg;
        out_ds_next      = out_ds_reg;
        cti_pending_next = cti_pending_reg;
        halted_next      = halted_reg;
        out_entry_next   = out_entry_reg;
        out_ctl_next     = out_ctl_reg;

        if (flush) begin
            // Flush overrides any same-cycle enqueue/load; out_* data holds.
            wr_ptr_next      = '0;
            rd_ptr_next      = '0;
            level_next       = '0;
            out_valid_next   = 1'b0;
            cti_pending_next = 1'b0;
            halted_next      = 1'b0;
        end else begin
            wr_ptr_next = wr_ptr_reg + (enq ? PW'(bus.in_count) : '0);
            rd_ptr_next = rd_ptr_reg + (load ? PW'(1) : '0);
            level_next  = level_reg + (enq ? LW'(bus.in_count) : '0) - (load ? LW'(1) : '0);

            if (load) begin
                out_valid_next   = 1'b1;
                out_entry_next   = head_entry;
                out_ctl_next     = head_ctl;
                // Delay-slot tag reflects the previously emitted instruction.
                out_ds_next      = cti_pending_reg;
                cti_pending_next = is_cti(head_ctl);
                halted_next      = halted_reg ||
                                   (STOP && (head_ctl.pc_src == selector::PC_SRC_EXECPTION));
            end else if (out_valid_reg && bus.out_ready) begin
                out_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            level_reg       <= '0;
            out_valid_reg   <= 1'b0;
            out_ds_reg      <= 1'b0;
            cti_pending_reg <= 1'b0;
            halted_reg      <= 1'b0;
            out_entry_reg   <= '0;
            out_ctl_reg     <= decoder_util::get_default_control();
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            level_reg       <= level_next;
            out_valid_reg   <= out_valid_next;
            out_ds_reg      <= out_ds_next;
            cti_pending_reg <= cti_pending_next;
            halted_reg      <= halted_next;
            out_entry_reg   <= out_entry_next;
            out_ctl_reg     <= out_ctl_next;
        end
    end

    assign bus.out_valid      = out_valid_reg;
    assign bus.out_instr      = out_entry_reg.instr;
    assign bus.out_pc         = out_entry_reg.pc;
    assign bus.out_ctl        = out_ctl_reg;
    assign bus.out_delay_slot = out_ds_reg;
    assign halted             = halted_reg;
    assign level              = level_reg;
endmodule
